// File: rtl/draw_scheduler.sv
// Command FIFO plus a three-state sequencer that hands one shape at a time to the
// fillscreen / circle / reuleaux engines and forwards the active engine's plot stream.
module draw_scheduler #(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [2:0]    cmd_colour,
   input  logic [7:0]    cmd_x,
   input  logic [6:0]    cmd_y,
   input  logic [7:0]    cmd_size,
   output logic [2:0]    eng_start,
   input  logic [2:0]    eng_done,
   output logic [2:0]    eng_colour,
   output logic [7:0]    eng_x,
   output logic [6:0]    eng_y,
   output logic [7:0]    eng_size,
   input  logic [23:0]   eng_vga_x,
   input  logic [20:0]   eng_vga_y,
   input  logic [8:0]    eng_vga_colour,
   input  logic [2:0]    eng_vga_plot,
   output logic [7:0]    vga_x,
   output logic [6:0]    vga_y,
   output logic [2:0]    vga_colour,
   output logic          vga_plot,
   output logic          busy,
   output logic [CW-1:0] fifo_count
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [1:0] op;
      logic [2:0] colour;
      logic [7:0] x;
      logic [6:0] y;
      logic [7:0] size;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

   cmd_t          mem_q [DEPTH];
   logic [AW-1:0] wrPtr_q, rdPtr_q;
   logic [CW-1:0] count_q;
   logic          full, empty, push, pop;
   cmd_t          head;

   state_t        state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [2:0]    start_q, start_d;
   logic [2:0]    colour_q, colour_d;
   logic [7:0]    x_q, x_d;
   logic [6:0]    y_q, y_d;
   logic [7:0]    size_q, size_d;
   logic          selDone;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = cmd_valid && !full;
   assign pop   = (state_q == IDLE) && !empty;
   assign head  = mem_q[rdPtr_q];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= '{cmd_op, cmd_colour, cmd_x, cmd_y, cmd_size};
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + AW'(1);
         if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_comb begin
      selDone = 1'b0;
      case (sel_q)
         2'd0:    selDone = eng_done[0];
         2'd1:    selDone = eng_done[1];
         2'd2:    selDone = eng_done[2];
         default: selDone = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         start_q  <= '0;
         colour_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         size_q   <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         start_q  <= start_d;
         colour_q <= colour_d;
         x_q      <= x_d;
         y_q      <= y_d;
         size_q   <= size_d;
      end
   end

   // A reserved op is popped and dropped without leaving IDLE.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      start_d  = start_q;
      colour_d = colour_q;
      x_d      = x_q;
      y_d      = y_q;
      size_d   = size_q;
      case (state_q)
         IDLE: begin
            if (pop && head.op != 2'd3) begin
               state_d  = RUN;
               sel_d    = head.op;
               start_d  = 3'b001 << head.op;
               colour_d = head.colour;
               x_d      = head.x;
               y_d      = head.y;
               size_d   = head.size;
            end
         end
         RUN: begin
            if (selDone) begin
               state_d = RELEASE;
               start_d = '0;
            end
         end
         RELEASE: begin
            start_d = '0;
            if (!selDone) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            start_d = '0;
         end
      endcase
   end

   always_comb begin
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_plot   = 1'b0;
      if (state_q == RUN) begin
         case (sel_q)
            2'd0: begin
               vga_x      = eng_vga_x[7:0];
               vga_y      = eng_vga_y[6:0];
               vga_colour = eng_vga_colour[2:0];
               vga_plot   = eng_vga_plot[0];
            end
            2'd1: begin
               vga_x      = eng_vga_x[15:8];
               vga_y      = eng_vga_y[13:7];
               vga_colour = eng_vga_colour[5:3];
               vga_plot   = eng_vga_plot[1];
            end
            2'd2: begin
               vga_x      = eng_vga_x[23:16];
               vga_y      = eng_vga_y[20:14];
               vga_colour = eng_vga_colour[8:6];
               vga_plot   = eng_vga_plot[2];
            end
            default: vga_plot = 1'b0;
         endcase
      end
      busy       = (state_q != IDLE) || !empty;
      cmd_ready  = !full;
      fifo_count = count_q;
      eng_start  = start_q;
      eng_colour = colour_q;
      eng_x      = x_q;
      eng_y      = y_q;
      eng_size   = size_q;
   end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: stub engines with per-engine done latency and
// a scoreboard of accepted commands checked against each engine start.
module tb_draw_scheduler;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct {
      logic [1:0] op;
      logic [2:0] colour;
      logic [7:0] x;
      logic [6:0] y;
      logic [7:0] size;
   } cmd_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_op;
   logic [2:0]    cmd_colour;
   logic [7:0]    cmd_x;
   logic [6:0]    cmd_y;
   logic [7:0]    cmd_size;
   logic [2:0]    eng_start, eng_done;
   logic [2:0]    eng_colour;
   logic [7:0]    eng_x;
   logic [6:0]    eng_y;
   logic [7:0]    eng_size;
   logic [23:0]   eng_vga_x;
   logic [20:0]   eng_vga_y;
   logic [8:0]    eng_vga_colour;
   logic [2:0]    plotIn;
   logic [7:0]    vga_x;
   logic [6:0]    vga_y;
   logic [2:0]    vga_colour;
   logic          vga_plot, busy;
   logic [CW-1:0] fifo_count;

   cmd_t sbQ[$];
   int   assertCount = 0;
   int   failCount   = 0;
   int   cyc         = 0;

   logic [2:0] doneStub, doneForce, donePrev;
   int         lat [3];
   int         cnt [3];
   bit         autoDone;
   int         doneFallCyc = 0;

   draw_scheduler #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_colour(cmd_colour), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_size(cmd_size),
      .eng_start(eng_start), .eng_done(eng_done), .eng_colour(eng_colour),
      .eng_x(eng_x), .eng_y(eng_y), .eng_size(eng_size),
      .eng_vga_x(eng_vga_x), .eng_vga_y(eng_vga_y),
      .eng_vga_colour(eng_vga_colour), .eng_vga_plot(plotIn),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stub engines raise done lat[i] cycles into a start and drop it once start falls.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         doneStub <= '0;
         for (int i = 0; i < 3; i++) cnt[i] <= 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (eng_start[i]) begin
               if (autoDone && !doneStub[i]) begin
                  if (cnt[i] >= lat[i]) doneStub[i] <= 1'b1;
                  else cnt[i] <= cnt[i] + 1;
               end
            end else begin
               doneStub[i] <= 1'b0;
               cnt[i]      <= 0;
            end
         end
      end
   end

   assign eng_done = doneStub | doneForce;

   always @(negedge clk) begin
      if ((donePrev & ~eng_done) != 3'b000) doneFallCyc <= cyc;
      donePrev <= eng_done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [2:0] colour,
                                input logic [7:0] x, input logic [6:0] y,
                                input logic [7:0] size, output bit accepted);
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_colour = colour;
      cmd_x      = x;
      cmd_y      = y;
      cmd_size   = size;
      accepted   = cmd_ready;
      tick();
      cmd_valid  = 1'b0;
      if (accepted && op != 2'd3) sbQ.push_back('{op, colour, x, y, size});
   endtask

   task automatic waitStart(input string tag, output int startCyc);
      int   n = 0;
      cmd_t e;
      while (eng_start == 3'b000 && n < 400) begin
         tick();
         n++;
      end
      startCyc = cyc;
      checkOutput({tag, " sbPending"}, 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
         e = sbQ.pop_front();
         checkOutput({tag, " start"},  32'(eng_start),  32'(3'b001 << e.op));
         checkOutput({tag, " colour"}, 32'(eng_colour), 32'(e.colour));
         checkOutput({tag, " x"},      32'(eng_x),      32'(e.x));
         checkOutput({tag, " y"},      32'(eng_y),      32'(e.y));
         checkOutput({tag, " size"},   32'(eng_size),   32'(e.size));
      end
   endtask

   task automatic waitStartLow(input string tag);
      int n = 0;
      while (eng_start != 3'b000 && n < 400) begin
         tick();
         n++;
      end
      checkOutput({tag, " startLow"}, 32'(eng_start), 32'd0);
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (busy && n < 600) begin
         tick();
         n++;
      end
      checkOutput({tag, " busy"},  32'(busy),       32'd0);
      checkOutput({tag, " count"}, 32'(fifo_count), 32'd0);
   endtask

   initial begin
      bit acc;
      bit accLast;
      int acceptCyc, startCyc, n;

      rst_n          = 1'b0;
      cmd_valid      = 1'b0;
      cmd_op         = '0;
      cmd_colour     = '0;
      cmd_x          = '0;
      cmd_y          = '0;
      cmd_size       = '0;
      doneForce      = '0;
      donePrev       = '0;
      autoDone       = 1'b1;
      lat[0]         = 10;
      lat[1]         = 20;
      lat[2]         = 50;
      eng_vga_x      = {8'hC2, 8'hB1, 8'hA0};
      eng_vga_y      = {7'h52, 7'h41, 7'h30};
      eng_vga_colour = {3'd6, 3'd5, 3'd4};
      plotIn         = 3'b111;

      #2;
      checkOutput("rst count", 32'(fifo_count), 32'd0);
      checkOutput("rst ready", 32'(cmd_ready),  32'd1);
      checkOutput("rst busy",  32'(busy),       32'd0);
      checkOutput("rst start", 32'(eng_start),  32'd0);
      checkOutput("rst plot",  32'(vga_plot),   32'd0);
      checkOutput("rst vgax",  32'(vga_x),      32'd0);
      checkOutput("rst engx",  32'(eng_x),      32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      $display("[TB] single circle command");
      applyStimulus(2'd1, 3'b010, 8'd80, 7'd60, 8'd20, acc);
      acceptCyc = cyc;
      checkOutput("single noStartYet", 32'(eng_start),  32'd0);
      checkOutput("single queued",     32'(fifo_count), 32'd1);
      checkOutput("single busy",       32'(busy),       32'd1);
      tick();
      waitStart("single", startCyc);
      checkOutput("single latency", 32'(startCyc - acceptCyc), 32'd1);
      checkOutput("single vgax",    32'(vga_x),      32'hB1);
      checkOutput("single vgay",    32'(vga_y),      32'h41);
      checkOutput("single vgacol",  32'(vga_colour), 32'd5);
      checkOutput("single plot",    32'(vga_plot),   32'd1);
      plotIn = 3'b101;
      #1;
      checkOutput("single plotOther", 32'(vga_plot), 32'd0);
      plotIn = 3'b111;
      n = 0;
      while (!eng_done[1] && n < 100) begin
         tick();
         n++;
      end
      checkOutput("single doneSeen", 32'(eng_done[1]), 32'd1);
      tick();
      checkOutput("single startDrop", 32'(eng_start), 32'd0);
      checkOutput("single releaseVga", 32'(vga_x),    32'd0);
      checkOutput("single releaseBusy", 32'(busy),    32'd1);
      waitIdle("single");

      $display("[TB] three queued commands");
      applyStimulus(2'd0, 3'd1, 8'd0,  7'd0,  8'd0,  acc);
      applyStimulus(2'd2, 3'd4, 8'd80, 7'd60, 8'd80, acc);
      applyStimulus(2'd1, 3'd7, 8'd10, 7'd20, 8'd5,  acc);
      checkOutput("queue peak", 32'(fifo_count), 32'd2);
      waitStart("queue A", startCyc);
      waitStartLow("queue A");
      waitStart("queue B", startCyc);
      checkOutput("queue B gap", 32'(startCyc - doneFallCyc), 32'd2);
      waitStartLow("queue B");
      waitStart("queue C", startCyc);
      checkOutput("queue C gap", 32'(startCyc - doneFallCyc), 32'd2);
      waitIdle("queue");

      $display("[TB] full fifo");
      autoDone = 1'b0;
      accLast  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(2'd1, 3'(i), 8'(i + 1), 7'(i + 2), 8'(i + 3), acc);
         checkOutput("full accept", 32'(acc), 32'd1);
      end
      checkOutput("full ready", 32'(cmd_ready),  32'd0);
      applyStimulus(2'd1, 3'd7, 8'd99, 7'd99, 8'd99, accLast);
      checkOutput("full reject", 32'(accLast),    32'd0);
      checkOutput("full count",  32'(fifo_count), 32'd4);
      waitStart("full first", startCyc);
      autoDone = 1'b1;
      for (int i = 0; i < 4; i++) begin
         waitStartLow("full drain");
         waitStart("full drain", startCyc);
      end
      waitIdle("full");

      $display("[TB] push and pop together");
      autoDone = 1'b0;
      applyStimulus(2'd1, 3'd3, 8'd11, 7'd12, 8'd13, acc);
      applyStimulus(2'd2, 3'd6, 8'd21, 7'd22, 8'd23, acc);
      checkOutput("pushpop count", 32'(fifo_count), 32'd1);
      waitStart("pushpop first", startCyc);
      checkOutput("pushpop held", 32'(fifo_count), 32'd1);
      autoDone = 1'b1;
      waitStartLow("pushpop");
      waitStart("pushpop second", startCyc);
      waitIdle("pushpop");

      $display("[TB] reserved op dropped");
      applyStimulus(2'd1, 3'd2, 8'd30, 7'd31, 8'd32, acc);
      applyStimulus(2'd3, 3'd5, 8'd40, 7'd41, 8'd42, acc);
      applyStimulus(2'd1, 3'd4, 8'd50, 7'd51, 8'd52, acc);
      waitStart("reserved first", startCyc);
      waitStartLow("reserved");
      waitStart("reserved second", startCyc);
      checkOutput("reserved gap", 32'(startCyc - doneFallCyc), 32'd3);
      waitIdle("reserved");

      $display("[TB] cross-talk and reset");
      autoDone = 1'b0;
      applyStimulus(2'd2, 3'd3, 8'd1, 7'd2, 8'd30, acc);
      waitStart("xtalk", startCyc);
      plotIn    = 3'b001;
      doneForce = 3'b001;
      tick();
      tick();
      checkOutput("xtalk plot",  32'(vga_plot),  32'd0);
      checkOutput("xtalk start", 32'(eng_start), 32'b100);
      checkOutput("xtalk vgax",  32'(vga_x),     32'hC2);
      checkOutput("xtalk busy",  32'(busy),      32'd1);
      doneForce = 3'b000;
      plotIn    = 3'b111;
      applyStimulus(2'd0, 3'd1, 8'd0, 7'd0, 8'd0, acc);
      checkOutput("xtalk queued", 32'(fifo_count), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst start", 32'(eng_start),  32'd0);
      checkOutput("midrst plot",  32'(vga_plot),   32'd0);
      checkOutput("midrst vgax",  32'(vga_x),      32'd0);
      checkOutput("midrst busy",  32'(busy),       32'd0);
      checkOutput("midrst count", 32'(fifo_count), 32'd0);
      checkOutput("midrst ready", 32'(cmd_ready),  32'd1);
      checkOutput("midrst size",  32'(eng_size),   32'd0);
      sbQ.delete();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      checkOutput("postrst busy",  32'(busy),      32'd0);
      checkOutput("postrst start", 32'(eng_start), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
